wb_write_arbiter: RTL

- Sole writer of the register file's single write port; merges the in-order pipeline write-back stream with results from long-latency units (mult/div, late loads).
- Long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- Exports a per-register busy mask to the hazard unit.
- Sits between the MEM/WB stage, the long-latency unit and the register file's reg_write/write_reg/write_data inputs.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/wb_write_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants and write-back request type
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WORD_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     data;
    } wb_req_t;

    // $0 maps to an empty mask so it can never be marked busy
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != ZERO_REG) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - long-latency result FIFO with per-entry squash and two-entry head view
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0]     push_data,
    input  logic [1:0]            pop_cnt,
    input  logic                  squash_en,
    input  logic [REG_ADDR_W-1:0] squash_reg,
    output logic                  full,
    output logic                  empty,
    output logic                  two,
    output logic [REG_ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0]     head_data,
    output logic                  head_sq,
    output logic [REG_ADDR_W-1:0] next_reg,
    output logic [DATA_W-1:0]     next_data,
    output logic                  next_sq
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             wr_ptr, rd_ptr, count;
    logic [AW-1:0]           wr_idx, rd_idx, nx_idx;
    logic [REG_ADDR_W-1:0]   reg_mem  [DEPTH];
    logic [DATA_W-1:0]       data_mem [DEPTH];
    logic [DEPTH-1:0]        vld, sq;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign nx_idx = rd_idx + 1'b1;
    assign count  = wr_ptr - rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);
    assign two   = (count >= (AW+1)'(2));

    assign head_reg  = reg_mem[rd_idx];
    assign head_data = data_mem[rd_idx];
    assign head_sq   = sq[rd_idx];
    assign next_reg  = reg_mem[nx_idx];
    assign next_data = data_mem[nx_idx];
    assign next_sq   = sq[nx_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_idx]  <= push_reg;
            data_mem[wr_idx] <= push_data;
        end
    end

    // Only live, not-yet-squashed entries match; at most one per register exists
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
            sq     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && vld[i] && !sq[i] && reg_mem[i] == squash_reg)
                    sq[i] <= 1'b1;
            end
            if (pop_cnt != 2'd0) vld[rd_idx] <= 1'b0;
            if (pop_cnt == 2'd2) vld[nx_idx] <= 1'b0;
            if (push) begin
                vld[wr_idx] <= 1'b1;
                sq[wr_idx]  <= 1'b0;
            end
            rd_ptr <= rd_ptr + (AW+1)'(pop_cnt);
            wr_ptr <= wr_ptr + (AW+1)'(push);
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write-port arbiter; WB_FWD_EN adds decode forwarding ports
module wb_write_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_reg,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  lr_valid,
    output logic                  lr_ready,
    input  logic [REG_ADDR_W-1:0] lr_reg,
    input  logic [DATA_W-1:0]     lr_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic [NUM_REGS-1:0]   busy
`ifdef WB_FWD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_reg_1,
    input  logic [REG_ADDR_W-1:0] fwd_reg_2,
    output logic                  fwd_hit_1,
    output logic                  fwd_hit_2,
    output logic [DATA_W-1:0]     fwd_data_1,
    output logic [DATA_W-1:0]     fwd_data_2
`endif
);

    logic                  full, empty, two, head_sq, next_sq;
    logic [REG_ADDR_W-1:0] head_reg, next_reg;
    logic [DATA_W-1:0]     head_data, next_data;
    logic                  pipe_sel, push, squash_en;
    logic [1:0]            pop_cnt;
    logic                  drain_valid;
    logic [REG_ADDR_W-1:0] drain_reg;
    logic [DATA_W-1:0]     drain_data;
    logic [NUM_REGS-1:0]   busy_next;

    assign pipe_sel  = pipe_valid && (pipe_reg != ZERO_REG);
    assign lr_ready  = !full && !busy[lr_reg];
    assign push      = lr_valid && lr_ready && (lr_reg != ZERO_REG);
    assign squash_en = pipe_sel && busy[pipe_reg];

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .push_reg   (lr_reg),
        .push_data  (lr_data),
        .pop_cnt    (pop_cnt),
        .squash_en  (squash_en),
        .squash_reg (pipe_reg),
        .full       (full),
        .empty      (empty),
        .two        (two),
        .head_reg   (head_reg),
        .head_data  (head_data),
        .head_sq    (head_sq),
        .next_reg   (next_reg),
        .next_data  (next_data),
        .next_sq    (next_sq)
    );

    // A squashed head is discarded for free; the entry behind it may use the idle port
    always_comb begin
        pop_cnt     = 2'd0;
        drain_valid = 1'b0;
        drain_reg   = head_reg;
        drain_data  = head_data;
        if (!empty) begin
            if (head_sq) begin
                pop_cnt = 2'd1;
                if (!pipe_sel && two && !next_sq) begin
                    pop_cnt     = 2'd2;
                    drain_valid = 1'b1;
                    drain_reg   = next_reg;
                    drain_data  = next_data;
                end
            end else if (!pipe_sel) begin
                pop_cnt     = 2'd1;
                drain_valid = 1'b1;
            end
        end
    end

    always_comb begin
        busy_next = busy;
        if (push)        busy_next = busy_next | reg_onehot(lr_reg);
        if (squash_en)   busy_next = busy_next & ~reg_onehot(pipe_reg);
        if (drain_valid) busy_next = busy_next & ~reg_onehot(drain_reg);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            busy       <= '0;
        end else begin
            busy <= busy_next;
            if (pipe_sel) begin
                reg_write  <= 1'b1;
                write_reg  <= pipe_reg;
                write_data <= pipe_data;
            end else if (drain_valid) begin
                reg_write  <= 1'b1;
                write_reg  <= drain_reg;
                write_data <= drain_data;
            end else begin
                reg_write  <= 1'b0;
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit_1  = reg_write && (write_reg == fwd_reg_1) && (fwd_reg_1 != ZERO_REG);
    assign fwd_hit_2  = reg_write && (write_reg == fwd_reg_2) && (fwd_reg_2 != ZERO_REG);
    assign fwd_data_1 = write_data;
    assign fwd_data_2 = write_data;
`endif

endmodule
